// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and slave FSM state type.
// Imported by the memory slave and by later AHB slaves.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR,
        ST_ERR2
    } ahb_slv_state_e;

    // Byte lanes touched by a transfer of the given size at the given lane offset.
    function automatic logic [7:0] ahb_byte_en(input logic [2:0] size, input logic [2:0] off);
        logic [7:0] m;
        case (size)
            HSIZE_BYTE: m = 8'h01;
            HSIZE_HALF: m = 8'h03;
            HSIZE_WORD: m = 8'h0F;
            default:    m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/ahb_mem_slave_array.sv
// Single-port synchronous memory with per-byte write enables.
// The read register only updates on a read strobe, so it holds the last read word.
module ahb_mem_array #(
  parameter int unsigned DEPTH     = 8192,
  parameter int unsigned WIDTH     = 32,
  parameter string       INIT_FILE = ""
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     i_re,
  input  logic [WIDTH/8-1:0]       i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge HCLK) begin
    for (int unsigned b = 0; b < WIDTH/8; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite ROM/RAM slave: address/data pipeline, configurable wait states,
// two-cycle ERROR response and a read-after-write stall on the single memory port.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned SIZE_WORDS  = 8192,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WRITABLE    = 0,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = "../ram_init_file/rom_init.hex"
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned OFFW  = $clog2(BYTES);
    localparam int unsigned AW    = $clog2(SIZE_WORDS);
    localparam logic [32:0] SIZE_BYTES = 33'(SIZE_WORDS) * 33'(BYTES);

    ahb_slv_state_e r_state, w_next;
    logic [3:0]      r_cnt, w_cnt_next;
    logic [AW-1:0]   r_widx;
    logic [OFFW-1:0] r_boff;
    logic [2:0]      r_size;
    logic            r_write;
    logic            r_dp_valid;

    logic [32:0]      w_rel;
    logic [AW-1:0]    w_idx;
    logic             w_ready, w_take, w_err, w_raw, w_commit, w_mem_re;
    logic [7:0]       w_be8;
    logic [BYTES-1:0] w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic             w_unused;

    // Underflow below BASE_ADDR shows up as bit 32 of the 33-bit difference.
    assign w_rel   = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign w_idx   = w_rel[OFFW +: AW];
    assign w_ready = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign w_take  = HSEL & HREADY & HTRANS[1] & w_ready;
    assign w_err   = w_rel[32] | (w_rel >= SIZE_BYTES)
                   | (HSIZE > 3'(OFFW))
                   | (|(HADDR[7:0] & ~(8'hFF << HSIZE)))
                   | (HWRITE & (WRITABLE == 0));
    assign w_commit = (r_state == ST_IDLE) & r_dp_valid & r_write;
    assign w_raw    = w_take & ~w_err & ~HWRITE & w_commit;
    assign w_unused = ^{HBURST, w_rel};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_widx     <= '0;
            r_boff     <= '0;
            r_size     <= '0;
            r_write    <= 1'b0;
            r_dp_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_ready) r_dp_valid <= w_take & ~w_err;
            if (w_take) begin
                r_widx  <= w_idx;
                r_boff  <= HADDR[OFFW-1:0];
                r_size  <= HSIZE;
                r_write <= HWRITE;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_next = ST_IDLE;
                if (w_take) begin
                    if (w_err) begin
                        w_next = ST_ERR;
                    end else if ((WAIT_STATES != 0) || w_raw) begin
                        w_next     = ST_WAIT;
                        w_cnt_next = 4'(WAIT_STATES) + {3'b000, w_raw};
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) w_next = ST_IDLE;
            end
            ST_ERR:  w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    // A read stalled behind a committing write is re-issued on the last wait cycle.
    assign w_be8      = ahb_byte_en(r_size, 3'(r_boff));
    assign w_mem_we   = w_commit ? w_be8[BYTES-1:0] : '0;
    assign w_mem_re   = (w_take & ~w_err & ~HWRITE & ~w_raw)
                      | ((r_state == ST_WAIT) & (r_cnt == 4'd1) & r_dp_valid & ~r_write);
    assign w_mem_addr = ((r_state == ST_WAIT) || w_commit) ? r_widx : w_idx;

    ahb_mem_array #(
        .DEPTH     (SIZE_WORDS),
        .WIDTH     (DATA_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_re    (w_mem_re),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (HWDATA),
        .o_rdata (HRDATA)
    );

    assign HREADYOUT = w_ready;
    assign HRESP     = ((r_state == ST_ERR) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Scoreboard bench: four slave configurations behind a small decoder/HREADY mux,
// directed vectors push expected responses, a monitor pops them at data-phase end.
module tb_ahb_mem_slave;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  m_dev;
    logic        m_hsel, m_issue, m_hwrite;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic [2:0]  m_hsize, m_hburst;
    logic [63:0] m_hwdata;

    logic [1:0]  r_dp_dev;
    logic [3:0]  hsel_v, hro, hrs;
    logic [31:0] rd0, rd2, rd3;
    logic [63:0] rd1;
    logic        w_hready, w_hresp;
    logic [63:0] w_rdata;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_sel
        assign hsel_v[g] = m_hsel && (m_dev == 2'(g));
    end

    always_comb begin
        w_hready = hro[r_dp_dev];
        w_hresp  = hrs[r_dp_dev];
        case (r_dp_dev)
            2'd0:    w_rdata = {32'h0, rd0};
            2'd1:    w_rdata = rd1;
            2'd2:    w_rdata = {32'h0, rd2};
            default: w_rdata = {32'h0, rd3};
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         r_dp_dev <= 2'd0;
        else if (w_hready) r_dp_dev <= m_dev;
    end

    ahb_mem_slave #(.SIZE_WORDS(8192), .DATA_WIDTH(32), .WRITABLE(0), .WAIT_STATES(0), .INIT_FILE("")) u_rom (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_v[0]), .HADDR(m_haddr), .HTRANS(m_htrans),
        .HWRITE(m_hwrite), .HSIZE(m_hsize), .HBURST(m_hburst), .HWDATA(m_hwdata[31:0]),
        .HREADY(w_hready), .HRDATA(rd0), .HREADYOUT(hro[0]), .HRESP(hrs[0]));

    ahb_mem_slave #(.SIZE_WORDS(256), .DATA_WIDTH(64), .WRITABLE(1), .WAIT_STATES(2), .INIT_FILE("")) u_ram64 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_v[1]), .HADDR(m_haddr), .HTRANS(m_htrans),
        .HWRITE(m_hwrite), .HSIZE(m_hsize), .HBURST(m_hburst), .HWDATA(m_hwdata),
        .HREADY(w_hready), .HRDATA(rd1), .HREADYOUT(hro[1]), .HRESP(hrs[1]));

    ahb_mem_slave #(.SIZE_WORDS(64), .DATA_WIDTH(32), .WRITABLE(1), .WAIT_STATES(0), .INIT_FILE("")) u_ram32 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_v[2]), .HADDR(m_haddr), .HTRANS(m_htrans),
        .HWRITE(m_hwrite), .HSIZE(m_hsize), .HBURST(m_hburst), .HWDATA(m_hwdata[31:0]),
        .HREADY(w_hready), .HRDATA(rd2), .HREADYOUT(hro[2]), .HRESP(hrs[2]));

    ahb_mem_slave #(.SIZE_WORDS(16), .DATA_WIDTH(32), .WRITABLE(1), .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
        .HCLK(clk), .HRESETn(rstn), .HSEL(hsel_v[3]), .HADDR(m_haddr), .HTRANS(m_htrans),
        .HWRITE(m_hwrite), .HSIZE(m_hsize), .HBURST(m_hburst), .HWDATA(m_hwdata[31:0]),
        .HREADY(w_hready), .HRDATA(rd3), .HREADYOUT(hro[3]), .HRESP(hrs[3]));

    typedef struct {
        string       name;
        int          waits;
        bit          resp;
        bit          chk;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input string what, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: %s got %h expected %h", name, what, got, exp);
        end
    endtask

    task automatic issue(input string name, input int dev, input bit sel, input logic [1:0] trans,
                         input bit wr, input logic [2:0] size, input logic [31:0] addr,
                         input logic [63:0] wdata, input int waits, input bit resp,
                         input bit chk, input logic [63:0] data, input bit push);
        int t;
        m_dev    = 2'(dev);
        m_hsel   = sel;
        m_htrans = trans;
        m_hwrite = wr;
        m_hsize  = size;
        m_haddr  = addr;
        m_issue  = 1'b1;
        if (push) sb.push_back('{name, waits, resp, chk, data});
        t = 0;
        @(negedge clk);
        while (!w_hready && t < 64) begin
            t++;
            @(negedge clk);
        end
        if (!w_hready) begin
            n_err++;
            $display("FAIL %s: address phase not accepted within 64 cycles, HREADY %b expected 1", name, w_hready);
        end
        @(posedge clk);
        #1;
        m_hwdata = wdata;
        m_issue  = 1'b0;
        m_hsel   = 1'b0;
        m_htrans = 2'b00;
        m_hwrite = 1'b0;
    endtask

    // Monitor: closes a data phase on the first HREADY-high cycle after acceptance.
    initial begin : monitor
        bit   in_dp;
        int   waits;
        bit   lowresp;
        exp_t e;
        in_dp = 0; waits = 0; lowresp = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                in_dp = 0;
                continue;
            end
            if (in_dp) begin
                if (!w_hready) begin
                    waits++;
                    lowresp |= w_hresp;
                end else begin
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected: data phase completed, queue depth %0d expected >0", sb.size());
                    end else begin
                        e = sb.pop_front();
                        check(e.name, "wait cycles", 64'(waits), 64'(e.waits));
                        check(e.name, "HRESP", {63'h0, w_hresp}, {63'h0, e.resp});
                        if (e.waits > 0) check(e.name, "HRESP while stalled", {63'h0, lowresp}, {63'h0, e.resp});
                        if (e.chk) check(e.name, "HRDATA", w_rdata, e.data);
                    end
                    in_dp = 0;
                end
            end
            if (w_hready && m_issue) begin
                in_dp = 1; waits = 0; lowresp = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        m_dev = 0; m_hsel = 0; m_issue = 0; m_hwrite = 0; m_haddr = '0;
        m_htrans = 2'b00; m_hsize = 3'd2; m_hburst = 3'd0; m_hwdata = '0;
        rstn = 1'b0;

        u_rom.u_mem.r_mem[0]    = 32'h0BAD_F00D;
        u_rom.u_mem.r_mem[5]    = 32'hDEAD_BEEF;
        u_rom.u_mem.r_mem[8191] = 32'h7FFC_7FFC;
        for (int k = 8; k < 12; k++) u_rom.u_mem.r_mem[k] = 32'hB000_0000 | 32'(k);
        u_ram64.u_mem.r_mem[1]  = 64'h0011_2233_4455_6677;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("reset", "HREADYOUT", {63'h0, hro[i]}, 64'h1);
            check("reset", "HRESP", {63'h0, hrs[i]}, 64'h0);
        end
        check("reset", "HRDATA rom", {32'h0, rd0}, 64'h0);
        check("reset", "HRDATA ram64", rd1, 64'h0);
        check("reset", "HRDATA ram32", {32'h0, rd2}, 64'h0);
        check("reset", "HRDATA ws3", {32'h0, rd3}, 64'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        //     name            dev sel trans  wr size  addr          wdata                   wt rsp chk data
        issue("rom_rd_14",      0, 1, 2'b10, 0, 3'd2, 32'h0000_0014, 64'h0,                  0, 0, 1, 64'hDEAD_BEEF, 1);
        issue("rom_wr_0",       0, 1, 2'b10, 1, 3'd2, 32'h0000_0000, 64'hFFFF_FFFF,          1, 1, 0, 64'h0,         1);
        issue("rom_rd_0",       0, 1, 2'b10, 0, 3'd2, 32'h0000_0000, 64'h0,                  0, 0, 1, 64'h0BAD_F00D, 1);
        issue("rom_rd_last",    0, 1, 2'b10, 0, 3'd2, 32'h0000_7FFC, 64'h0,                  0, 0, 1, 64'h7FFC_7FFC, 1);
        issue("rom_rd_oor",     0, 1, 2'b10, 0, 3'd2, 32'h0000_8000, 64'h0,                  1, 1, 0, 64'h0,         1);
        issue("rom_half_mis",   0, 1, 2'b10, 0, 3'd1, 32'h0000_0001, 64'h0,                  1, 1, 0, 64'h0,         1);
        issue("rom_dword",      0, 1, 2'b10, 0, 3'd3, 32'h0000_0000, 64'h0,                  1, 1, 0, 64'h0,         1);
        issue("rom_idle",       0, 1, 2'b00, 0, 3'd2, 32'h0000_0014, 64'h0,                  0, 0, 0, 64'h0,         1);
        issue("rom_busy",       0, 1, 2'b01, 0, 3'd2, 32'h0000_0014, 64'h0,                  0, 0, 0, 64'h0,         1);
        issue("rom_unsel",      0, 0, 2'b10, 0, 3'd2, 32'h0000_0014, 64'h0,                  0, 0, 0, 64'h0,         1);
        m_hburst = 3'd3;
        issue("burst_b0",       0, 1, 2'b10, 0, 3'd2, 32'h0000_0020, 64'h0,                  0, 0, 1, 64'hB000_0008, 1);
        issue("burst_b1",       0, 1, 2'b11, 0, 3'd2, 32'h0000_0024, 64'h0,                  0, 0, 1, 64'hB000_0009, 1);
        issue("burst_b2",       0, 1, 2'b11, 0, 3'd2, 32'h0000_0028, 64'h0,                  0, 0, 1, 64'hB000_000A, 1);
        issue("burst_b3",       0, 1, 2'b11, 0, 3'd2, 32'h0000_002C, 64'h0,                  0, 0, 1, 64'hB000_000B, 1);
        m_hburst = 3'd0;
        issue("r64_wr_byte",    1, 1, 2'b10, 1, 3'd0, 32'h0000_000B, 64'hFFFF_FFFF_A5FF_FFFF, 2, 0, 0, 64'h0,        1);
        issue("r64_idle",       1, 1, 2'b00, 0, 3'd3, 32'h0000_0000, 64'h0,                  0, 0, 0, 64'h0,         1);
        issue("r64_rd_dword",   1, 1, 2'b10, 0, 3'd3, 32'h0000_0008, 64'h0,                  2, 0, 1, 64'h0011_2233_A555_6677, 1);
        issue("r32_wr_40",      2, 1, 2'b10, 1, 3'd2, 32'h0000_0040, 64'h1234_5678,          0, 0, 0, 64'h0,         1);
        issue("r32_raw_rd",     2, 1, 2'b10, 0, 3'd2, 32'h0000_0040, 64'h0,                  1, 0, 1, 64'h1234_5678, 1);
        issue("r32_wr_half",    2, 1, 2'b10, 1, 3'd1, 32'h0000_0042, 64'hBEEF_1111,          0, 0, 0, 64'h0,         1);
        issue("r32_raw_rd2",    2, 1, 2'b10, 0, 3'd2, 32'h0000_0040, 64'h0,                  1, 0, 1, 64'hBEEF_5678, 1);
        issue("r32_oor",        2, 1, 2'b10, 0, 3'd2, 32'h0000_0100, 64'h0,                  1, 1, 0, 64'h0,         1);
        issue("ws3_wr_4",       3, 1, 2'b10, 1, 3'd2, 32'h0000_0004, 64'hCAFE_0001,          3, 0, 0, 64'h0,         1);
        issue("ws3_idle",       3, 1, 2'b00, 0, 3'd2, 32'h0000_0000, 64'h0,                  0, 0, 0, 64'h0,         1);
        issue("ws3_rd_4",       3, 1, 2'b10, 0, 3'd2, 32'h0000_0004, 64'h0,                  3, 0, 1, 64'hCAFE_0001, 1);
        issue("ws3_rd_reset",   3, 1, 2'b10, 0, 3'd2, 32'h0000_0004, 64'h0,                  3, 0, 0, 64'h0,         0);

        check("ws3_mid", "HREADYOUT before reset", {63'h0, hro[3]}, 64'h0);
        #3;
        rstn = 1'b0;
        #1;
        check("ws3_mid_reset", "HREADYOUT", {63'h0, hro[3]}, 64'h1);
        check("ws3_mid_reset", "HRESP", {63'h0, hrs[3]}, 64'h0);
        check("ws3_mid_reset", "HRDATA", {32'h0, rd3}, 64'h0);
        check("scoreboard", "entries left", 64'(sb.size()), 64'h0);

        repeat (2) @(posedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
